// File: rtl/half_subractor_pkg.sv
// Shared constants for the half subtractor: default widths and the per-bit
// truth table, indexed by {a,b}.
package half_subractor_pkg;

  localparam int unsigned DEF_WIDTH = 1;
  localparam int unsigned DEF_CNT_W = 8;

  // Bit {a,b} of each table gives the result for that operand pair.
  localparam logic [3:0] TT_DIFF = 4'b0110;
  localparam logic [3:0] TT_BOR  = 4'b0010;

endpackage : half_subractor_pkg

// File: rtl/half_sub_cell.sv
// One-bit half subtractor: difference and borrow of a minus b.
module half_sub_cell (
  output logic diff,
  output logic bor,
  input  logic a,
  input  logic b
);

  assign diff = a ^ b;
  assign bor  = ~a & b;

endmodule : half_sub_cell

// File: rtl/half_subractor.sv
// WIDTH-bit bitwise half subtractor with a registered result stage and a
// saturating count of accepted samples that produced any borrow.
module half_subractor
  import half_subractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] bor,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff_q,
  output logic [WIDTH-1:0] bor_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] bor_cnt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    half_sub_cell u_cell (
      .diff (diff[i]),
      .bor  (bor[i]),
      .a    (a[i]),
      .b    (b[i])
    );
  end

  logic any_bor;
  logic cnt_full;

  assign any_bor  = |bor;
  assign cnt_full = (bor_cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q    <= '0;
      bor_q     <= '0;
      out_valid <= 1'b0;
      bor_cnt   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff_q <= diff;
        bor_q  <= bor;
        // Counter sticks at all-ones rather than wrapping.
        if (any_bor && !cnt_full) begin
          bor_cnt <= bor_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule : half_subractor

// File: tb/tb_half_subractor.sv
// Bench for half_subractor: three instances (1-bit, 4-bit, 1-bit with 2-bit
// counter) against an arithmetic reference model, plus directed literal checks.
module tb_half_subractor;
  import half_subractor_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Instance 0: WIDTH=1, CNT_W=8
  logic       a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
  logic       d1, r1, dq1, rq1, ov1;
  logic [7:0] c1;
  // Instance 1: WIDTH=4, CNT_W=8
  logic [3:0] a4 = '0, b4 = '0;
  logic       v4 = 1'b0;
  logic [3:0] d4, r4, dq4, rq4;
  logic       ov4;
  logic [7:0] c4;
  // Instance 2: WIDTH=1, CNT_W=2
  logic       ac = 1'b0, bc = 1'b0, vc = 1'b0;
  logic       dc, rc, dqc, rqc, ovc;
  logic [1:0] cc;

  half_subractor #(.WIDTH(1), .CNT_W(8)) u1 (
    .diff(d1), .bor(r1), .a(a1), .b(b1), .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .diff_q(dq1), .bor_q(rq1), .out_valid(ov1), .bor_cnt(c1));
  half_subractor #(.WIDTH(4), .CNT_W(8)) u4 (
    .diff(d4), .bor(r4), .a(a4), .b(b4), .clk(clk), .rst_n(rst_n),
    .in_valid(v4), .diff_q(dq4), .bor_q(rq4), .out_valid(ov4), .bor_cnt(c4));
  half_subractor #(.WIDTH(1), .CNT_W(2)) uc (
    .diff(dc), .bor(rc), .a(ac), .b(bc), .clk(clk), .rst_n(rst_n),
    .in_valid(vc), .diff_q(dqc), .bor_q(rqc), .out_valid(ovc), .bor_cnt(cc));

  localparam int CMAX [3] = '{255, 255, 3};

  logic [3:0] in_a [3], in_b [3];
  logic       in_v [3];
  logic [3:0] o_d [3], o_r [3], o_dq [3], o_rq [3];
  logic       o_ov [3];
  logic [7:0] o_c [3];

  always_comb begin
    in_a[0] = {3'b0, a1}; in_b[0] = {3'b0, b1}; in_v[0] = v1;
    in_a[1] = a4;         in_b[1] = b4;         in_v[1] = v4;
    in_a[2] = {3'b0, ac}; in_b[2] = {3'b0, bc}; in_v[2] = vc;
    o_d[0] = {3'b0, d1}; o_r[0] = {3'b0, r1}; o_dq[0] = {3'b0, dq1};
    o_rq[0] = {3'b0, rq1}; o_ov[0] = ov1; o_c[0] = c1;
    o_d[1] = d4; o_r[1] = r4; o_dq[1] = dq4; o_rq[1] = rq4;
    o_ov[1] = ov4; o_c[1] = c4;
    o_d[2] = {3'b0, dc}; o_r[2] = {3'b0, rc}; o_dq[2] = {3'b0, dqc};
    o_rq[2] = {3'b0, rqc}; o_ov[2] = ovc; o_c[2] = {6'b0, cc};
  end

  // Per bit: difference is (a-b) mod 2, borrow is whether a < b.
  function automatic logic [3:0] f_diff(logic [3:0] x, logic [3:0] y);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (((int'(x[i]) - int'(y[i])) % 2) != 0);
    return r;
  endfunction

  function automatic logic [3:0] f_bor(logic [3:0] x, logic [3:0] y);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (int'(x[i]) < int'(y[i]));
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model of the registered stage.
  logic [3:0] m_dq [3] = '{default: '0};
  logic [3:0] m_rq [3] = '{default: '0};
  logic       m_ov [3] = '{default: 1'b0};
  int         m_cnt [3] = '{default: 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_dq[k] <= '0; m_rq[k] <= '0; m_ov[k] <= 1'b0; m_cnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_ov[k] <= in_v[k];
        if (in_v[k]) begin
          m_dq[k] <= f_diff(in_a[k], in_b[k]);
          m_rq[k] <= f_bor(in_a[k], in_b[k]);
          if (f_bor(in_a[k], in_b[k]) != 4'b0)
            m_cnt[k] <= (m_cnt[k] + 1 > CMAX[k]) ? CMAX[k] : m_cnt[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("diff%0d", k), 32'(o_d[k]), 32'(f_diff(in_a[k], in_b[k])));
        chk($sformatf("bor%0d", k), 32'(o_r[k]), 32'(f_bor(in_a[k], in_b[k])));
        chk($sformatf("diff_q%0d", k), 32'(o_dq[k]), 32'(m_dq[k]));
        chk($sformatf("bor_q%0d", k), 32'(o_rq[k]), 32'(m_rq[k]));
        chk($sformatf("out_valid%0d", k), 32'(o_ov[k]), 32'(m_ov[k]));
        chk($sformatf("bor_cnt%0d", k), 32'(o_c[k]), 32'(m_cnt[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] ab;
    logic [3:0] exp_d;
    logic [3:0] exp_b;
    exp_d = 4'b0110;
    exp_b = 4'b0010;
    #1 rst_n = 1'b0;
    // Truth-table sweep while held in reset, 2 ns per combination.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1]; b1 = ab[0];
      #1;
      chk("tt_diff", 32'(d1), 32'(exp_d[i]));
      chk("tt_bor", 32'(r1), 32'(exp_b[i]));
      chk("tt_pkg_diff", 32'(d1), 32'(TT_DIFF[i]));
      chk("tt_pkg_bor", 32'(r1), 32'(TT_BOR[i]));
      chk("rst_dq", 32'(dq1), 32'(0));
      #1;
    end
    chk_en = 1'b1;
    repeat (3) tick();
    chk("rst_ov", 32'(ov1), 32'(0));
    chk("rst_cnt", 32'(c1), 32'(0));
    chk("rst_cnt_c", 32'(cc), 32'(0));

    // First edge after release accepts a=0,b=1 on every instance.
    rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
    ac = 1'b0; bc = 1'b1; vc = 1'b1;
    a4 = 4'b0101; b4 = 4'b0011; v4 = 1'b1;
    #1;
    chk("w4_diff", 32'(d4), 32'h6);
    chk("w4_bor", 32'(r4), 32'h2);
    tick();
    chk("one_dq", 32'(dq1), 32'(1));
    chk("one_bq", 32'(rq1), 32'(1));
    chk("one_ov", 32'(ov1), 32'(1));
    chk("one_cnt", 32'(c1), 32'(1));
    chk("w4_dq", 32'(dq4), 32'h6);
    chk("w4_bq", 32'(rq4), 32'h2);
    chk("sat_cnt1", 32'(cc), 32'(1));
    v1 = 1'b0; v4 = 1'b0;
    tick();
    chk("idle_ov", 32'(ov1), 32'(0));
    chk("idle_dq", 32'(dq1), 32'(1));
    chk("sat_cnt2", 32'(cc), 32'(2));
    tick();
    chk("sat_cnt3", 32'(cc), 32'(3));
    tick();
    chk("sat_cnt4", 32'(cc), 32'(3));
    tick();
    chk("sat_cnt5", 32'(cc), 32'(3));
    vc = 1'b0;

    for (int n = 0; n < 300; n++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); v1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); v4 = 1'($urandom);
      ac = 1'($urandom); bc = 1'($urandom); vc = 1'($urandom);
      tick();
      if (n == 150) begin
        // Short reset pulse between edges, then a normal accept.
        #1 rst_n = 1'b0;
        #1;
        chk("pulse_dq", 32'(dq1), 32'(0));
        chk("pulse_bq", 32'(rq1), 32'(0));
        chk("pulse_ov", 32'(ov1), 32'(0));
        chk("pulse_cnt", 32'(c1), 32'(0));
        chk("pulse_cnt4", 32'(c4), 32'(0));
        chk("pulse_cntc", 32'(cc), 32'(0));
        chk("pulse_diff4", 32'(d4), 32'(a4 ^ b4));
        #1 rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
        tick();
        chk("post_dq", 32'(dq1), 32'(1));
        chk("post_bq", 32'(rq1), 32'(0));
        chk("post_ov", 32'(ov1), 32'(1));
        chk("post_cnt", 32'(c1), 32'(0));
      end
    end
    chk_en = 1'b0;
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_half_subractor

// File: doc/half_subractor.md
HALF_SUBRACTOR -- requirements
Module: half_subractor

Interface
Parameters:
REQ-001 The block SHALL provide parameter WIDTH, default 1, as the operand and result bit width.
REQ-002 The block SHALL provide parameter CNT_W, default 8, as the borrow-event counter width.

Ports:
REQ-003 The block SHALL provide port clk, input, 1 bit, as the single rising-edge clock.
REQ-004 The block SHALL provide port rst_n, input, 1 bit, as the asynchronous active-low reset.
REQ-005 The block SHALL provide port diff, output, WIDTH bits, as the combinational difference a minus b.
REQ-006 The block SHALL provide port bor, output, WIDTH bits, as the combinational per-bit borrow.
REQ-007 The block SHALL provide port a, input, WIDTH bits, as the minuend.
REQ-008 The block SHALL provide port b, input, WIDTH bits, as the subtrahend.
REQ-009 The block SHALL provide port in_valid, input, 1 bit, as the sample-accept strobe.
REQ-010 The block SHALL provide port diff_q, output, WIDTH bits, as the registered difference.
REQ-011 The block SHALL provide port bor_q, output, WIDTH bits, as the registered borrow.
REQ-012 The block SHALL provide port out_valid, output, 1 bit, as the registered result-valid flag.
REQ-013 The block SHALL provide port bor_cnt, output, CNT_W bits, as the count of accepted samples that produced a borrow.
REQ-014 Ports SHALL be declared in the order diff, bor, a, b, clk, rst_n, in_valid, diff_q, bor_q, out_valid, bor_cnt, so that a four-port positional hookup (diff, bor, a, b) stays legal.
REQ-015 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-016 diff SHALL equal a XOR b, bitwise, purely combinational, with no dependence on clk, rst_n or in_valid.
REQ-017 bor SHALL equal (NOT a) AND b, bitwise, purely combinational.
REQ-018 Per bit, the (a,b) to (diff,bor) mapping SHALL be: 00 to 0,0; 01 to 1,1; 10 to 1,0; 11 to 0,0.
REQ-019 Combinational outputs SHALL settle within the same timestep as an input change; there are no latches or feedback paths.
REQ-020 On a rising clk edge with in_valid=1, diff_q SHALL load diff, bor_q SHALL load bor, and out_valid SHALL be set to 1 (latency one cycle).
REQ-021 On a rising clk edge with in_valid=0, out_valid SHALL be set to 0, and diff_q and bor_q SHALL hold their values.
REQ-022 On each accepted sample (in_valid=1) where any bit of bor is 1, bor_cnt SHALL increment by 1.
REQ-023 bor_cnt SHALL saturate at all-ones; it never wraps.
REQ-024 Back-to-back in_valid cycles SHALL each be accepted, giving one result per cycle with no stall.
REQ-025 Out-of-range inputs SHALL not exist: every 2^(2*WIDTH) input combination is legal and fully defined.

Reset
REQ-026 While rst_n=0, diff_q, bor_q, out_valid and bor_cnt SHALL be 0, asynchronously, independent of clk.
REQ-027 Reset SHALL NOT affect diff or bor, which continue tracking a and b.
REQ-028 An in_valid=1 sample on the first rising edge after rst_n deasserts SHALL be accepted normally.
REQ-029 Reset asserted between accepted samples SHALL discard the registered result and clear bor_cnt immediately.

Structure
REQ-030 A shared package SHALL hold the WIDTH and CNT_W default constants and the per-bit truth-table constants used by the bench.
REQ-031 The design SHALL contain one sub-module, half_sub_cell (1-bit diff/bor), instantiated WIDTH times in a generate loop; the registers and counter live in the top module.

Verification
REQ-032 With WIDTH=1, the bench SHALL drive (a,b) = 00, 01, 10, 11 at 2 ns intervals and require (diff,bor) = (0,0), (1,1), (1,0), (0,0) respectively.
REQ-033 With rst_n=0 and clk toggling, the bench SHALL require diff_q=0, bor_q=0, out_valid=0 and bor_cnt=0, while diff and bor still follow a and b.
REQ-034 With in_valid=1 for one cycle at a=0, b=1, the bench SHALL require diff_q=1, bor_q=1, out_valid=1 and bor_cnt=1 after the edge, then out_valid=0 on the next edge with in_valid=0.
REQ-035 With CNT_W=2 and five accepted samples at a=0, b=1, the bench SHALL require bor_cnt to read 1, 2, 3, 3, 3.
REQ-036 With WIDTH=4, a=4'b0101 and b=4'b0011, the bench SHALL require diff=4'b0110 and bor=4'b0010, with the registered copies equal one cycle later.
REQ-037 With rst_n pulsed low mid-stream for less than a clock period, the bench SHALL require immediate clearing of all registered outputs and correct accept on the next edge.
